// File: rtl/pair_gate_pipe_pkg.sv
// Shared definitions for the pair-gate pipeline: op encoding and the per-pair
// two-input gate evaluation.
package pair_gate_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_t;

    function automatic logic pair_eval(input op_t op, input logic in0, input logic in1);
        logic y;
        case (op)
            OP_AND:  y = in0 & in1;
            OP_OR:   y = in0 | in1;
            OP_XOR:  y = in0 ^ in1;
            OP_NAND: y = ~(in0 & in1);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/pair_gate_pipe_stage.sv
// One pipeline register stage holding valid, y and z; loads only when the
// shared advance enable is high, so bubbles move with the data.
module pair_gate_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_y,
    input  logic [WIDTH-1:0] d_z,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_y,
    output logic [WIDTH-1:0] q_z
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_y     <= '0;
            q_z     <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_y     <= d_y;
            q_z     <= d_z;
        end
    end

endmodule

// File: rtl/pair_gate_pipe.sv
// Bank of NUM_PAIRS selectable two-input gates feeding a STAGES-deep
// valid/ready pipeline, with a wrapping count of completed output transfers.
module pair_gate_pipe
    import pair_gate_pkg::*;
#(
    parameter int unsigned NUM_PAIRS = 4,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*NUM_PAIRS-1:0] in_data,
    input  logic [OP_W-1:0]        in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_PAIRS-1:0]   out_y,
    output logic [NUM_PAIRS-1:0]   out_z,
    output logic [CNT_W-1:0]       out_count
);

    logic                 en;
    logic [NUM_PAIRS-1:0] eval_y;
    logic [NUM_PAIRS-1:0] eval_z;
    logic [STAGES:0]      valid_pipe;
    logic [NUM_PAIRS-1:0] y_pipe [0:STAGES];
    logic [NUM_PAIRS-1:0] z_pipe [0:STAGES];
    logic [CNT_W-1:0]     count;

    // Whole pipe advances in lockstep; bubbles are only squeezed out by the
    // output side draining, never by an internal stall.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
        assign eval_y[k] = pair_eval(op_t'(in_op), in_data[2*k], in_data[2*k+1]);
        assign eval_z[k] = ~in_data[2*k];
    end

    assign valid_pipe[0] = in_valid;
    assign y_pipe[0]     = eval_y;
    assign z_pipe[0]     = eval_z;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        pair_gate_stage #(
            .WIDTH (NUM_PAIRS)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .d_valid (valid_pipe[s-1]),
            .d_y     (y_pipe[s-1]),
            .d_z     (z_pipe[s-1]),
            .q_valid (valid_pipe[s]),
            .q_y     (y_pipe[s]),
            .q_z     (z_pipe[s])
        );
    end

    assign out_valid = valid_pipe[STAGES];
    assign out_y     = y_pipe[STAGES];
    assign out_z     = z_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (out_valid && out_ready) begin
            count <= count + CNT_W'(1);
        end
    end

    assign out_count = count;

endmodule

// File: doc/pair_gate_pipe.md
Name: pair_gate_pipe

Overview:
- Parametrised, pipelined successor to the two-input pair-gate cells.
- Splits a packed input word into NUM_PAIRS bit pairs. Per pair, computes a run-time-selected two-input logic op (y) and the inverted first input (z).
- Registers the results through STAGES pipeline stages under a valid/ready handshake, and counts completed output transfers.
- Sits between a valid/ready producer and consumer anywhere a bank of pair gates is instantiated.

Parameters:
- NUM_PAIRS, 4, number of bit pairs (>=1); input word width is 2*NUM_PAIRS.
- STAGES, 2, pipeline register stages (>=1); sets latency.
- CNT_W, 16, width of the output-transfer counter (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  2*NUM_PAIRS  packed pairs; pair k: in0=in_data[2k], in1=in_data[2k+1].
- in_op  input  2  op select, sampled with in_data.
- out_valid  output  1  out_y/out_z valid.
- out_ready  input  1  consumer accepts.
- out_y  output  NUM_PAIRS  y[k]=op(in0_k,in1_k).
- out_z  output  NUM_PAIRS  z[k]=~in0_k.
- out_count  output  CNT_W  number of output handshakes, modulo 2^CNT_W.

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND. All four codes are legal; there is no illegal-op case.
- Logic evaluation is combinational from in_data/in_op into the stage-1 register. Stages 2..STAGES are pure delay. Each stage holds valid, y and z.
- Global advance enable: en = ~out_valid | out_ready. in_ready = en, a combinational path from out_ready, which is permitted.
- On a rising edge with en=1:
  - stage1.valid <= in_valid, and stage1 y/z load the evaluated values.
  - stage i loads stage i-1, including bubbles.
- With en=0, all stages hold. Input is not accepted while in_ready=0.
- Input handshake: in_valid & in_ready at edge n. The word appears on the outputs after edge n+STAGES-1 (registered output). Sustained throughput is one word per cycle.
- Output handshake: out_valid & out_ready.
  - The output must stay stable while out_valid=1 and out_ready=0.
  - Order is preserved. No loss, no duplication.
- Bubbles are not collapsed while stalled. While out_valid=0 the pipe free-runs and bubbles propagate.
- out_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Reset (async assert, synchronous deassert is the system's responsibility):
  - All stage valids, y, z and out_count go to 0 immediately.
  - So out_valid=0, out_y=0, out_z=0, out_count=0.
  - in_ready=1 during and after reset.
  - Reset mid-stream discards all in-flight words.
- Simultaneous input and output handshake in the same cycle: both occur. The pipe shifts and occupancy is unchanged.
- in_valid=0 with en=1: a bubble enters and no state other than shifting changes.

Decomposition:
- Package pair_gate_pkg holds:
  - op enum (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3);
  - a function pair_eval(op, in0, in1) returning y;
  - OP_W=2.
- One sub-module, pair_gate_stage: one pipeline register stage (valid, y, z; enable, async active-low reset). It is instantiated STAGES times by a generate loop.
- Per-pair evaluation is a generate loop in the top using pair_eval.

Test Plan:
1. Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_y=0, out_z=0, out_count=0 without a clock edge. in_ready=1.
2. Defaults. in_data=8'b1101_0110, out_ready=1, in_op=AND/OR/XOR/NAND on four consecutive cycles:
   - out_y = 4'b1000, 4'b1111, 4'b0111, 4'b0111;
   - out_z = 4'b0001 each;
   - first word appears after edge n+1, then one word per cycle.
3. out_ready=0, three back-to-back valid words A,B,C:
   - A and B are held, with A stable on the outputs;
   - in_ready=0 once full, and C is held by the source;
   - release out_ready -> A, B, C emerge in order and out_count +3.
4. out_ready=1 and in_valid=1 for 10 cycles with random data/op:
   - 10 outputs match the scoreboard model;
   - out_count=10; no idle cycles after fill.
5. CNT_W=4, 17 transfers -> out_count=1 (wrap at 16).
6. STAGES=1, NUM_PAIRS=1. in_data=2'b11, op=XOR -> out_y=0 and out_z=0 after the accepting edge. The random handshake toggling scoreboard passes.
